// File: rtl/app_hd_readout_pkg.sv
// Shared constants and FSM encoding for the APP hard-decision readout sequencer.
// Build option: APP_HD_READOUT_OREG_EN (see app_hd_readout.sv).
package app_hd_readout_pkg;

  // Decoder geometry: lanes per APP word and bits per lane value
  localparam int DEF_IN_NUM  = 32;
  localparam int DEF_V_WIDTH = 6;

  // APP RAM geometry: words per frame (Zc/IN_NUM) and matching address width
  localparam int DEF_DEPTH   = 128;
  localparam int DEF_ADDR_W  = 7;

  // APP RAM read latency in cycles; legal range 1..4
  localparam int DEF_RD_LAT  = 1;

  // Width of one APP word as seen on the collector bus
  localparam int DEF_DATA_W  = DEF_IN_NUM * DEF_V_WIDTH;

  // Sequencer states; encoding is shared with the collector side
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } rd_state_t;

endpackage

// File: rtl/app_rd_delay_pipe.sv
// LAT-deep shift register carrying the APP read valid and address so they
// line up with the RAM read data. Synchronous flush empties every stage.
module app_rd_delay_pipe #(
  parameter int LAT = 1,
  parameter int AW  = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [AW-1:0] in_addr,
  output logic          out_valid,
  output logic [AW-1:0] out_addr
);

  logic [LAT-1:0] vld;
  logic [AW-1:0]  adr [LAT];

  // Advance valid/address one stage per clock; reset or flush drops all beats in flight
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      vld <= '0;
      for (int i = 0; i < LAT; i++) begin
        adr[i] <= '0;
      end
    end else begin
      vld[0] <= in_valid;
      adr[0] <= in_addr;
      for (int i = 1; i < LAT; i++) begin
        vld[i] <= vld[i-1];
        adr[i] <= adr[i-1];
      end
    end
  end

  assign out_valid = vld[LAT-1];
  assign out_addr  = adr[LAT-1];

endmodule

// File: rtl/app_hd_readout.sv
// APP RAM readout sequencer feeding the hard-decision collector.
// A start pulse sweeps addresses 0..DEPTH-1; each returned word leaves on
// data_out/addr_out/en_out as one unbroken DEPTH-beat burst, then done pulses.
// Build option: define APP_HD_READOUT_OREG_EN to add an output register on
// data_out/addr_out/en_out (latency RD_LAT+1, done one cycle later).
module app_hd_readout
  import app_hd_readout_pkg::*;
#(
  parameter int IN_NUM  = DEF_IN_NUM,
  parameter int V_WIDTH = DEF_V_WIDTH,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int RD_LAT  = DEF_RD_LAT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  output logic                      busy,
  output logic                      done,
  output logic                      ram_rd_en,
  output logic [ADDR_W-1:0]         ram_rd_addr,
  input  logic [IN_NUM*V_WIDTH-1:0] ram_rd_data,
  output logic [IN_NUM*V_WIDTH-1:0] data_out,
  output logic [ADDR_W-1:0]         addr_out,
  output logic                      en_out
);

  localparam int DATA_W = IN_NUM * V_WIDTH;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  rd_state_t           state;
  logic                flush;
  logic                pipe_valid;
  logic [ADDR_W-1:0]   pipe_addr;
  logic                stage_en;
  logic [ADDR_W-1:0]   stage_addr;
  logic [DATA_W-1:0]   stage_data;
  logic                last_beat;

  // An abort only has an effect outside IDLE; it empties the beats in flight
  assign flush = abort && (state != ST_IDLE);

  app_rd_delay_pipe #(
    .LAT (RD_LAT),
    .AW  (ADDR_W)
  ) u_delay_pipe (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (ram_rd_en),
    .in_addr   (ram_rd_addr),
    .out_valid (pipe_valid),
    .out_addr  (pipe_addr)
  );

  // Gate address and RAM data with the delayed valid so nothing stale reaches the collector
  always_comb begin
    stage_en   = pipe_valid;
    stage_addr = '0;
    stage_data = '0;
    if (pipe_valid) begin
      stage_addr = pipe_addr;
      stage_data = ram_rd_data;
    end else begin
      stage_addr = '0;
      stage_data = '0;
    end
  end

`ifdef APP_HD_READOUT_OREG_EN
  // Extra register stage on the wide collector bus; cleared together with the pipe
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      en_out   <= 1'b0;
      addr_out <= '0;
      data_out <= '0;
    end else begin
      en_out   <= stage_en;
      addr_out <= stage_addr;
      data_out <= stage_data;
    end
  end
`else
  assign en_out   = stage_en;
  assign addr_out = stage_addr;
  assign data_out = stage_data;
`endif

  // The final beat of the burst is the one carrying the last address
  assign last_beat = en_out && (addr_out == LAST_ADDR);

  // Sequencer FSM: issues the read sweep, waits for the pipe to drain, pulses done
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      ram_rd_en   <= 1'b0;
      ram_rd_addr <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else if (flush) begin
      // Abort: silent return to IDLE, no done pulse
      state       <= ST_IDLE;
      ram_rd_en   <= 1'b0;
      ram_rd_addr <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start && !abort) begin
            state       <= ST_READ;
            ram_rd_en   <= 1'b1;
            ram_rd_addr <= '0;
            busy        <= 1'b1;
          end else begin
            ram_rd_en   <= 1'b0;
            busy        <= 1'b0;
          end
        end
        ST_READ: begin
          if (ram_rd_addr == LAST_ADDR) begin
            // Last read issued this cycle; the counter holds at DEPTH-1
            state     <= ST_DRAIN;
            ram_rd_en <= 1'b0;
          end else begin
            ram_rd_addr <= ram_rd_addr + ADDR_W'(1);
          end
        end
        ST_DRAIN: begin
          if (last_beat) begin
            state <= ST_FIN;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            state <= ST_DRAIN;
          end
        end
        ST_FIN: begin
          // start arriving alongside done is deliberately not looked at here
          state <= ST_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state       <= ST_IDLE;
          ram_rd_en   <= 1'b0;
          ram_rd_addr <= '0;
          busy        <= 1'b0;
          done        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_app_hd_readout.sv
// Self-checking bench for app_hd_readout: two instances (RD_LAT=1 and 3) share
// start/abort/rst, each reads its own latency-accurate RAM model, and a
// timing-rule reference model predicts every output cycle by cycle.
module tb_app_hd_readout;

  localparam int DW    = 192;
  localparam int AW    = 7;
  localparam int DEPTH = 128;
`ifdef APP_HD_READOUT_OREG_EN
  localparam int OREG  = 1;
`else
  localparam int OREG  = 0;
`endif
  localparam int LAT [2] = '{1, 3};

  logic          clk;
  logic          rst;
  logic          start;
  logic          abort;
  logic          busy        [2];
  logic          done        [2];
  logic          ram_rd_en   [2];
  logic [AW-1:0] ram_rd_addr [2];
  logic [DW-1:0] ram_rd_data [2];
  logic [DW-1:0] data_out    [2];
  logic [AW-1:0] addr_out    [2];
  logic          en_out      [2];

  logic [DW-1:0] mem   [DEPTH];
  logic [DW-1:0] rpipe [2][4];

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // reference model state per instance: running flag and accepted start cycle
  bit act [2];
  int t0  [2];

  app_hd_readout #(.RD_LAT(1)) u_dut_l1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .busy(busy[0]), .done(done[0]),
    .ram_rd_en(ram_rd_en[0]), .ram_rd_addr(ram_rd_addr[0]), .ram_rd_data(ram_rd_data[0]),
    .data_out(data_out[0]), .addr_out(addr_out[0]), .en_out(en_out[0])
  );

  app_hd_readout #(.RD_LAT(3)) u_dut_l3 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .busy(busy[1]), .done(done[1]),
    .ram_rd_en(ram_rd_en[1]), .ram_rd_addr(ram_rd_addr[1]), .ram_rd_data(ram_rd_data[1]),
    .data_out(data_out[1]), .addr_out(addr_out[1]), .en_out(en_out[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW/32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // cycle counter: value n during the cycle that follows the n-th rising edge
  always @(posedge clk) cyc <= cyc + 1;

  // RAM models: read data appears LAT cycles after the read; garbage otherwise
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      for (int s = 3; s > 0; s--) rpipe[d][s] <= rpipe[d][s-1];
      rpipe[d][0] <= (ram_rd_en[d] === 1'b1) ? mem[ram_rd_addr[d]] : rand_word();
    end
  end
  assign ram_rd_data[0] = rpipe[0][LAT[0]-1];
  assign ram_rd_data[1] = rpipe[1][LAT[1]-1];

  task automatic check_inst(input int d);
    int k, ol;
    logic e_rd, e_en, e_done, e_busy;
    string p;
    ol = LAT[d] + OREG;
    k  = act[d] ? (cyc - t0[d]) : -1000;
    e_rd   = (k >= 1) && (k <= DEPTH);
    e_en   = (k >= 1 + ol) && (k <= DEPTH + ol);
    e_done = (k == DEPTH + 1 + ol);
    e_busy = (k >= 1) && (k <= DEPTH + ol);
    p = $sformatf("L%0d.", LAT[d]);
    check_eq({p, "ram_rd_en"}, DW'(ram_rd_en[d]), DW'(e_rd));
    if (e_rd) check_eq({p, "ram_rd_addr"}, DW'(ram_rd_addr[d]), DW'(k - 1));
    check_eq({p, "en_out"}, DW'(en_out[d]), DW'(e_en));
    if (e_en) begin
      check_eq({p, "addr_out"}, DW'(addr_out[d]), DW'(k - 1 - ol));
      check_eq({p, "data_out"}, data_out[d], mem[k - 1 - ol]);
    end else begin
      check_eq({p, "addr_out_idle"}, DW'(addr_out[d]), DW'(0));
      check_eq({p, "data_out_idle"}, data_out[d], DW'(0));
    end
    check_eq({p, "done"}, DW'(done[d]), DW'(e_done));
    check_eq({p, "busy"}, DW'(busy[d]), DW'(e_busy));
  endtask

  task automatic model_update(input int d);
    int ol;
    ol = LAT[d] + OREG;
    if (rst) begin
      act[d] = 1'b0;
    end else if (act[d]) begin
      if (abort || ((cyc - t0[d]) >= DEPTH + 1 + ol)) act[d] = 1'b0;
    end else if (start && !abort) begin
      act[d] = 1'b1;
      t0[d]  = cyc;
    end
  endtask

  // compare against the model for this cycle, then feed it this cycle's inputs
  always @(negedge clk) begin
    if (cyc >= 2) begin
      for (int d = 0; d < 2; d++) check_inst(d);
    end
    for (int d = 0; d < 2; d++) model_update(d);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    act[0] = 1'b0; act[1] = 1'b0; t0[0] = 0; t0[1] = 0;
    for (int a = 0; a < DEPTH; a++) mem[a] = rand_word();
    repeat (3) tick();
    rst = 1'b0;
    repeat (3) tick();

    // full sweep; start at T0+50 (busy) and at T0+130 (L1 done cycle) are ignored
    pulse_start();
    repeat (49) tick();
    pulse_start();
    repeat (79) tick();
    pulse_start();
    repeat (20) tick();

    // abort at T0+40, then a fresh sweep from address 0
    pulse_start();
    repeat (39) tick();
    abort = 1'b1; tick(); abort = 1'b0;
    repeat (5) tick();
    pulse_start();
    repeat (140) tick();

    // reset at T0+60, then a full sweep
    pulse_start();
    repeat (59) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    repeat (5) tick();
    pulse_start();
    repeat (140) tick();

    // abort and start together from IDLE: abort wins
    start = 1'b1; abort = 1'b1; tick();
    start = 1'b0; abort = 1'b0;
    repeat (10) tick();

    // randomized start/abort/reset traffic
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 99) == 0);
      abort = ($urandom_range(0, 599) == 0);
      rst   = ($urandom_range(0, 1999) == 0);
      tick();
    end
    start = 1'b0; abort = 1'b0; rst = 1'b0;
    repeat (150) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
